// File: rtl/stage_memory_mc.sv
// Pipeline memory stage: issues requests to a multi-cycle data memory, stalls
// upstream while an access is outstanding, and registers the MEM/WB boundary.
module stage_memory_mc #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] ALUResultIn,
  input  logic [15:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemToRegIn,
  input  logic [2:0]  WriteRegIn,
  input  logic        RegWriteIn,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic [15:0] DMemOutData,
  output logic [15:0] ALUResult,
  output logic        MemToReg,
  output logic [2:0]  WriteRegOut,
  output logic        RegWriteOut,
  output logic        stall,
  output logic        err
);

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q;
  logic [DW-1:0]    dmem_q, alu_q;
  logic             m2r_q;
  logic [RW-1:0]    wreg_q;
  logic             rw_q;
  logic             memop, illegal;
  logic             wb_load, wb_take_rdata;

  assign memop     = valid_in & (MemRead | MemWrite);
  assign illegal   = valid_in & MemRead & MemWrite;
  assign mem_addr  = ALUResultIn;
  assign mem_wdata = WriteData;

  // Next-state, request pulses, stall and MEM/WB load enables
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_rd        = 1'b0;
    mem_wr        = 1'b0;
    stall         = 1'b0;
    wb_load       = 1'b0;
    wb_take_rdata = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (memop) begin
          stall = 1'b1;
          if (illegal) begin
            state_d = S_ERR;
          end else begin
            mem_rd  = MemRead;
            mem_wr  = MemWrite;
            state_d = S_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end else begin
          wb_load = valid_in;
        end
      end
      S_WAIT: begin
        // Completion wins over timeout when both land in the same cycle
        if (mem_done) begin
          state_d       = S_IDLE;
          cnt_d         = '0;
          wb_load       = 1'b1;
          wb_take_rdata = MemRead;
        end else begin
          stall = 1'b1;
          if (cnt_q == CNT_W'(TIMEOUT)) begin
            state_d = S_ERR;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_ERR: begin
        stall = 1'b1;
      end
      default: begin
        state_d = S_ERR;
        stall   = 1'b1;
      end
    endcase
  end

  // State, counter, sticky error and MEM/WB register; no load means a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      dmem_q  <= '0;
      alu_q   <= '0;
      m2r_q   <= 1'b0;
      wreg_q  <= '0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_q | (state_d == S_ERR);
      if (wb_load) begin
        alu_q  <= ALUResultIn;
        m2r_q  <= MemToRegIn;
        wreg_q <= WriteRegIn;
        rw_q   <= RegWriteIn;
        if (wb_take_rdata) begin
          dmem_q <= mem_rdata;
        end
      end else begin
        rw_q <= 1'b0;
      end
    end
  end

  assign DMemOutData = dmem_q;
  assign ALUResult   = alu_q;
  assign MemToReg    = m2r_q;
  assign WriteRegOut = wreg_q;
  assign RegWriteOut = rw_q;
  assign err         = err_q;

endmodule
